// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core control path: opcodes, writeback
// selector codes, sequencer state encoding and instruction field positions.
package cpu_pkg;

    // Opcodes (instr[15:12]); 1..7 are ALU operations
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_LD  = 4'd10;
    localparam logic [3:0] OP_ST  = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12;
    localparam logic [3:0] OP_JZ  = 4'd13;
    localparam logic [3:0] OP_JAL = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Writeback selector codes
    localparam logic [2:0] SEL_RESULT = 3'd0;
    localparam logic [2:0] SEL_DATAIN = 3'd1;
    localparam logic [2:0] SEL_NUM    = 3'd2;
    localparam logic [2:0] SEL_ADDR   = 3'd3;
    localparam logic [2:0] SEL_RY     = 3'd4;

    // Instruction field positions for a 16-bit instruction word
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RX_MSB   = 11;
    localparam int RX_LSB   = 9;
    localparam int RSVD_BIT = 8;
    localparam int NUM_MSB  = 7;
    localparam int NUM_LSB  = 0;
    localparam int RY_MSB   = 2;
    localparam int RY_LSB   = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Coarse instruction class used to pick the state after DECODE
    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_WB     = 3'd2,
        CLS_MEM    = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_HALT   = 3'd5
    } op_class_e;

endpackage

// File: rtl/opcode_decode.sv
// Pure combinational opcode classifier: instruction class, writeback
// selector source, and memory/branch flags.
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_e  cls,
    output logic [2:0] wb_sel,
    output logic       is_mem,
    output logic       is_branch
);

    // Map each opcode to its class and writeback source
    always_comb begin
        cls       = CLS_ALU;
        wb_sel    = SEL_RESULT;
        is_mem    = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_NOP: cls = CLS_NOP;
            OP_LDI: begin
                cls    = CLS_WB;
                wb_sel = SEL_NUM;
            end
            OP_MOV: begin
                cls    = CLS_WB;
                wb_sel = SEL_RY;
            end
            OP_LD: begin
                cls    = CLS_MEM;
                wb_sel = SEL_DATAIN;
                is_mem = 1'b1;
            end
            OP_ST: begin
                cls    = CLS_MEM;
                is_mem = 1'b1;
            end
            OP_JMP, OP_JZ: begin
                cls       = CLS_BRANCH;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                cls    = CLS_WB;
                wb_sel = SEL_ADDR;
            end
            OP_HLT: cls = CLS_HALT;
            default: begin
                cls    = CLS_ALU;
                wb_sel = SEL_RESULT;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetches into IR, then sequences decode, execute,
// data-memory access and writeback, driving datapath enables.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int INSTR_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               fetch_req,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [2:0]         c_sel,
    output logic [2:0]         rx_addr,
    output logic [2:0]         ry_addr,
    output logic [7:0]         num,
    output logic [2:0]         alu_op,
    output logic               reg_we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               halted,
    output logic               bus_error
);

    // Last wait-counter value allowed before the access is declared dead
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               bus_error_q, bus_error_d;

    logic [3:0] opcode;
    op_class_e  cls;
    logic [2:0] wb_sel;
    logic       is_mem;
    logic       is_branch;
    logic       unused_rsvd;

    assign opcode      = ir_q[OPC_MSB:OPC_LSB];
    assign rx_addr     = ir_q[RX_MSB:RX_LSB];
    assign ry_addr     = ir_q[RY_MSB:RY_LSB];
    assign num         = ir_q[NUM_MSB:NUM_LSB];
    assign bus_error   = bus_error_q;
    // Reserved bit is carried in IR but has no meaning
    assign unused_rsvd = ir_q[RSVD_BIT];

    opcode_decode u_decode (
        .opcode    (opcode),
        .cls       (cls),
        .wb_sel    (wb_sel),
        .is_mem    (is_mem),
        .is_branch (is_branch)
    );

    // State, IR, wait counter and sticky error flag; reset abandons any access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            ir_q        <= '0;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next-state logic and control outputs; everything forced low during reset
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = bus_error_q;
        fetch_req   = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        c_sel       = SEL_RESULT;
        alu_op      = 3'd0;
        reg_we      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                wait_cnt_d = '0;
                case (cls)
                    CLS_ALU:  state_d = ST_EXEC;
                    CLS_WB:   state_d = ST_WB;
                    CLS_MEM:  state_d = is_mem ? ST_MEM : ST_FETCH;
                    CLS_BRANCH: begin
                        // JMP always loads; JZ only when the ALU flag is set
                        pc_load = is_branch && ((opcode == OP_JMP) || zero);
                        state_d = ST_FETCH;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                alu_op  = opcode[2:0];
                state_d = ST_WB;
            end
            ST_MEM: begin
                mem_rd = (opcode == OP_LD);
                mem_wr = (opcode == OP_ST);
                // A completion in the timeout cycle still counts as success
                if (mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = (opcode == OP_LD) ? ST_WB : ST_FETCH;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                c_sel   = wb_sel;
                // JAL: Rx captures the return address in the same edge the PC jumps
                pc_load = (opcode == OP_JAL);
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        if (!rst_n) begin
            fetch_req = 1'b0;
            pc_inc    = 1'b0;
            pc_load   = 1'b0;
            c_sel     = SEL_RESULT;
            alu_op    = 3'd0;
            reg_we    = 1'b0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            halted    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a vector table of single
// instructions plus hand-written timeout, reset and halt sequences.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        mem_ready;
    logic        zero;
    logic        fetch_req, pc_inc, pc_load, reg_we, mem_rd, mem_wr, halted, bus_error;
    logic [2:0]  c_sel, rx_addr, ry_addr, alu_op;
    logic [7:0]  num;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.MEM_TIMEOUT(15), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .fetch_req   (fetch_req),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .c_sel       (c_sel),
        .rx_addr     (rx_addr),
        .ry_addr     (ry_addr),
        .num         (num),
        .alu_op      (alu_op),
        .reg_we      (reg_we),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .halted      (halted),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        int          delay;
        int          e_cyc;
        int          e_we;
        int          e_ld;
        int          e_rd;
        int          e_wr;
        int          e_sel;
        int          e_alu;
        int          e_rx;
        int          e_num;
    } vec_t;

    typedef struct {
        int         cyc;
        int         we;
        int         ld;
        int         inc;
        int         rd;
        int         wr;
        int         stray;
        logic [2:0] sel;
        logic [2:0] alu;
        logic [2:0] rx;
        logic [7:0] num;
        logic       halt;
        logic       tmo;
    } obs_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one instruction from FETCH and observe until FETCH returns or HALT
    task automatic run_instr(input logic [15:0] ins, input logic z, input int delay,
                             input logic hold, output obs_t o);
        int  mk;
        logic done;
        mk = 0;
        done = 1'b0;
        o.cyc = 0; o.we = 0; o.ld = 0; o.inc = 0; o.rd = 0; o.wr = 0; o.stray = 0;
        o.sel = '0; o.alu = '0; o.rx = '0; o.num = '0; o.halt = 1'b0; o.tmo = 1'b0;
        zero = z;
        @(negedge clk);
        for (int c = 0; c < 64; c++) begin
            instr       = (c == 0) ? ins : 16'hC0FF;
            instr_valid = (c == 0) || hold;
            mem_ready   = 1'b0;
            #1;
            if (mem_rd || mem_wr) begin
                mk++;
                mem_ready = (mk > delay);
            end
            #1;
            if (c > 0 && fetch_req) begin
                done = 1'b1;
                break;
            end
            if (halted) begin
                o.halt = 1'b1;
                done = 1'b1;
                break;
            end
            o.cyc++;
            o.we  += int'(reg_we);
            o.ld  += int'(pc_load);
            o.inc += int'(pc_inc);
            o.rd  += int'(mem_rd);
            o.wr  += int'(mem_wr);
            if (reg_we) begin
                o.sel = c_sel;
                o.rx  = rx_addr;
                o.num = num;
            end else if (c_sel != 3'd0) begin
                o.stray++;
            end
            if (alu_op != 3'd0) o.alu = alu_op;
            @(negedge clk);
        end
        if (!done) o.tmo = 1'b1;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        obs_t o;
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0;

        // instr, zero, delay, cycles, we, pc_load, rd, wr, sel, alu, rx, num
        vecs[0]  = '{16'h8A05, 1'b0, 0,  3, 1, 0, 0,  0, 2, 0, 5, 8'h05};
        vecs[1]  = '{16'h9A03, 1'b0, 0,  3, 1, 0, 0,  0, 4, 0, 5, 8'h03};
        vecs[2]  = '{16'h3405, 1'b0, 0,  4, 1, 0, 0,  0, 0, 3, 2, 8'h05};
        vecs[3]  = '{16'h7E01, 1'b0, 0,  4, 1, 0, 0,  0, 0, 7, 7, 8'h01};
        vecs[4]  = '{16'hA620, 1'b0, 0,  4, 1, 0, 1,  0, 1, 0, 3, 8'h20};
        vecs[5]  = '{16'hA620, 1'b0, 3,  7, 1, 0, 4,  0, 1, 0, 3, 8'h20};
        vecs[6]  = '{16'hB240, 1'b0, 0,  3, 0, 0, 0,  1, 0, 0, 0, 8'h00};
        vecs[7]  = '{16'hB240, 1'b0, 14, 17, 0, 0, 0, 15, 0, 0, 0, 8'h00};
        vecs[8]  = '{16'hC040, 1'b0, 0,  2, 0, 1, 0,  0, 0, 0, 0, 8'h00};
        vecs[9]  = '{16'hD040, 1'b1, 0,  2, 0, 1, 0,  0, 0, 0, 0, 8'h00};
        vecs[10] = '{16'hD040, 1'b0, 0,  2, 0, 0, 0,  0, 0, 0, 0, 8'h00};
        vecs[11] = '{16'hEE10, 1'b0, 0,  3, 1, 1, 0,  0, 3, 0, 7, 8'h10};
        vecs[12] = '{16'h0000, 1'b0, 0,  2, 0, 0, 0,  0, 0, 0, 0, 8'h00};

        // Outputs while reset is held
        @(negedge clk);
        #1;
        chk("rst fetch_req", fetch_req, 0);
        chk("rst halted", halted, 0);
        chk("rst bus_error", bus_error, 0);
        chk("rst c_sel", c_sel, 0);
        chk("rst rx_addr", rx_addr, 0);
        rst_n = 1'b1;
        #1;
        chk("post-rst fetch_req", fetch_req, 1);
        $display("reset released fetch_req=%0d", fetch_req);

        // Table of single-instruction runs
        for (int i = 0; i < NVEC; i++) begin
            run_instr(vecs[i].ins, vecs[i].z, vecs[i].delay, 1'b0, o);
            $display("vec %0d instr=%h zero=%0d cycles=%0d we=%0d pc_load=%0d rd=%0d wr=%0d sel=%0d",
                     i, vecs[i].ins, vecs[i].z, o.cyc, o.we, o.ld, o.rd, o.wr, o.sel);
            chk($sformatf("v%0d timeout", i), o.tmo, 0);
            chk($sformatf("v%0d halt", i), o.halt, 0);
            chk($sformatf("v%0d cycles", i), o.cyc, vecs[i].e_cyc);
            chk($sformatf("v%0d reg_we", i), o.we, vecs[i].e_we);
            chk($sformatf("v%0d pc_load", i), o.ld, vecs[i].e_ld);
            chk($sformatf("v%0d pc_inc", i), o.inc, 1);
            chk($sformatf("v%0d mem_rd", i), o.rd, vecs[i].e_rd);
            chk($sformatf("v%0d mem_wr", i), o.wr, vecs[i].e_wr);
            chk($sformatf("v%0d c_sel", i), o.sel, vecs[i].e_sel);
            chk($sformatf("v%0d alu_op", i), o.alu, vecs[i].e_alu);
            chk($sformatf("v%0d stray c_sel", i), o.stray, 0);
            if (vecs[i].e_we != 0) begin
                chk($sformatf("v%0d rx_addr", i), o.rx, vecs[i].e_rx);
                chk($sformatf("v%0d num", i), o.num, vecs[i].e_num);
            end
        end
        chk("no bus_error after table", bus_error, 0);

        // instr_valid held high outside FETCH must not reload IR
        run_instr(16'h8A05, 1'b0, 0, 1'b1, o);
        $display("hold-valid LDI cycles=%0d sel=%0d rx=%0d num=%h", o.cyc, o.sel, o.rx, o.num);
        chk("hold cycles", o.cyc, 3);
        chk("hold pc_inc", o.inc, 1);
        chk("hold c_sel", o.sel, 2);
        chk("hold rx_addr", o.rx, 5);
        chk("hold num", o.num, 8'h05);

        // ST with no mem_ready: 15 MEM cycles then HALT with bus_error
        run_instr(16'hB240, 1'b0, 1000, 1'b0, o);
        $display("ST timeout cycles=%0d wr=%0d halt=%0d bus_error=%0d", o.cyc, o.wr, o.halt, bus_error);
        chk("tmo halt", o.halt, 1);
        chk("tmo cycles", o.cyc, 17);
        chk("tmo mem_wr cycles", o.wr, 15);
        chk("tmo bus_error", bus_error, 1);
        chk("tmo halted", halted, 1);
        chk("tmo mem_wr low", mem_wr, 0);
        instr = 16'h8A05;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("halt%0d fetch_req", k), fetch_req, 0);
            chk($sformatf("halt%0d halted", k), halted, 1);
        end
        instr_valid = 1'b0;
        reset_dut();

        // Reset arriving mid-MEM of an LD abandons the access
        @(negedge clk);
        instr = 16'hA620; instr_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midmem mem_rd", mem_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("midmem rst mem_rd", mem_rd, 0);
        chk("midmem rst reg_we", reg_we, 0);
        chk("midmem rst halted", halted, 0);
        chk("midmem rst fetch_req", fetch_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("mid-MEM reset released fetch_req=%0d bus_error=%0d", fetch_req, bus_error);
        chk("midmem post fetch_req", fetch_req, 1);
        chk("midmem post bus_error", bus_error, 0);
        chk("midmem post rx_addr", rx_addr, 0);

        // HLT stops the core
        run_instr(16'hF000, 1'b0, 0, 1'b0, o);
        $display("HLT cycles=%0d halt=%0d", o.cyc, o.halt);
        chk("hlt halt", o.halt, 1);
        chk("hlt cycles", o.cyc, 2);
        chk("hlt bus_error", bus_error, 0);
        @(negedge clk);
        #1;
        chk("hlt fetch_req", fetch_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
